// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter in front of one shared registered WIDTH-bit adder.
// A grant latches the winner's operands. The following cycle performs the add
// and pulses Valid with the result tagged by the owning requester's Id.
module adder_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] A_in,
  input  logic [NREQ*WIDTH-1:0] B_in,
  output logic [NREQ-1:0]       Gnt,
  output logic [WIDTH-1:0]      Sum,
  output logic                  Overflow,
  output logic                  Valid,
  output logic [IDW-1:0]        Id
);

  typedef enum logic [0:0] {StIdle, StAdd} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] op_a, op_b;

  // Round-robin pick: scan last+1, last+2, ... wrapping, ending at last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = IDW'((int'(last_q) + k) % int'(NREQ));
      if (!found && Req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Operand mux for the current winner, using constant part-selects only.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == win) begin
        op_a = A_in[i*WIDTH +: WIDTH];
        op_b = B_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: grant and latch in idle, add and pulse Valid in the add cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = NREQ'(1) << win;
          a_d     = op_a;
          b_d     = op_b;
          id_d    = win;
          last_d  = win;
          state_d = StAdd;
        end
      end
      StAdd: begin
        // Req is ignored here, so at most one grant per two cycles.
        {ovf_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
        valid_d        = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset discards any in-flight add.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign Gnt      = gnt_q;
  assign Sum      = sum_q;
  assign Overflow = ovf_q;
  assign Valid    = valid_q;
  assign Id       = id_q;

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one registered WIDTH-bit unsigned adder between NREQ requesters.
- Uses round-robin arbitration and a request/grant handshake.
- Each grant latches the winner's operands, performs one add, and returns Sum/Overflow with a one-cycle Valid pulse tagged by requester Id.
- Sits between the operand producers and the shared add datapath. It is the only block driving that datapath's enable.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, operand and Sum width in bits
IDW, 2, Id width; must equal ceil(log2(NREQ))

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Req  input  NREQ  per-requester request, level
A_in  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
B_in  input  NREQ*WIDTH  operand B; same packing as A_in
Gnt  output  NREQ  one-hot grant, one-cycle pulse, registered
Sum  output  WIDTH  result of last completed add, held between operations
Overflow  output  1  carry-out of last completed add, held
Valid  output  1  one-cycle pulse: Sum/Overflow/Id are new this cycle
Id  output  IDW  index of the requester that owns the current result

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous, active-low (Rst_n).
- Reset values:
  - Gnt=0, Valid=0, Sum=0, Overflow=0, Id=0.
  - FSM=IDLE, round-robin pointer last=NREQ-1 (so requester 0 has top priority after reset).
- FSM states:
  - IDLE: at an edge where Req!=0:
    - winner = first set Req bit scanning last+1, last+2, ... wrapping modulo NREQ, ending at last.
    - Gnt<=onehot(winner); latch A/B of winner; Id<=winner; last<=winner; FSM->ADD.
    - If Req==0: stay IDLE, Gnt<=0.
  - ADD: Gnt<=0.
    - {Overflow,Sum}<=latchedA+latchedB, computed as a WIDTH+1-bit unsigned add.
    - Valid<=1; FSM->IDLE. Req is ignored in this state.
- Valid is deasserted on every edge where it is not explicitly set.
- Latency:
  - Req sampled at edge k -> Gnt high during cycle k..k+1.
  - Valid, Sum and Overflow are presented after edge k+1.
- Throughput: one operation per 2 cycles. A new grant may be issued at the same edge at which Valid drops, i.e. a grant can overlap the Valid cycle's successor.
- Handshake:
  - A requester holds Req and its operands stable until it sees Gnt.
  - Operands are captured at the granting edge; later operand changes have no effect.
  - A requester deasserts Req in the cycle after Gnt unless it wants another operation. If Req stays high, it competes again under round-robin, so the others get priority first.
- Withdrawal: Req dropped before a grant is simply never served. No error is raised.
- Simultaneous requests: exactly one grant per arbitration. No requester waits more than NREQ-1 other grants.
- Arithmetic: unsigned. Overflow=1 iff A+B >= 2^WIDTH, and Sum = (A+B) mod 2^WIDTH.
- Sum/Overflow/Id hold their values until the next Valid.
- Reset mid-operation (Rst_n low while in ADD): the operation is discarded, no Valid is produced, and all outputs take reset values immediately.
- No combinational path from inputs to outputs.

Test Plan:
- Single requester: Req=0001, A0=3, B0=4 -> Gnt=0001 for 1 cycle; next cycle Valid=1, Sum=7, Overflow=0, Id=0; Sum holds 7 afterwards.
- Overflow: Req=0100, A2=9, B2=8 -> Valid with Sum=1, Overflow=1, Id=2. Also A2=15, B2=15 -> Sum=14, Overflow=1.
- All requesting continuously after reset: Req=1111 -> grant order 0,1,2,3,0, one grant every 2 cycles, Id sequence matches.
- Fairness after a grant: last=1, Req=1011 -> next grants in order 3, 0, 1.
- Operand change after grant: A0 changes from 5 to 12 in the ADD cycle with B0=1 -> Sum=6, not 13.
- Async reset: Rst_n low mid-cycle while in ADD -> Gnt, Valid, Sum, Overflow and Id go to 0 without a clock edge. After release with Req=1000 the first grant is 1000, and no stale Valid appears.
